apu_pulse_channel: RTL and testbench
====================================

APU_PULSE_CHANNEL -- requirements
Module: apu_pulse_channel

Interface
REQ-001 Parameter CHANNEL_ID, default 0, meaning sweep negate mode: 0 = ones' complement (subtract extra 1), 1 = two's complement.
REQ-002 Parameter OUT_WIDTH, default 4, meaning output width (>=4); the 4-bit level is left-shifted by OUT_WIDTH-4.
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 apu_tick  input  1  timer clock enable (one clk per APU cycle).
REQ-006 quarter_tick  input  1  frame-counter quarter-frame strobe (envelope).
REQ-007 half_tick  input  1  frame-counter half-frame strobe (length, sweep).
REQ-008 wr_en  input  1  register write strobe.
REQ-009 wr_addr  input  2  register select: 0=$4000, 1=$4001, 2=$4002, 3=$4003 equivalents.
REQ-010 wr_data  input  8  write data.
REQ-011 chan_enable  input  1  $4015 enable bit for this channel.
REQ-012 pulse  output  OUT_WIDTH  registered channel level.
REQ-013 length_active  output  1  high when length counter != 0.

Function
REQ-014 Field map SHALL be: addr0 = duty[7:6], loop/halt[5], const_vol[4], vol[3:0]; addr1 = sweep_en[7], sweep_period[6:4], negate[3], shift[2:0]; addr2 = period[7:0]; addr3 = length_idx[7:3], period[10:8].
REQ-015 Timer (11-bit) SHALL, on apu_tick: if count==0, reload with period and advance step; else decrement.
REQ-016 Step SHALL be 3-bit, advance downward 7->6->...->0->7 with wrap.
REQ-017 Duty bit for steps 0..7 SHALL be: duty0 01000000, duty1 01100000, duty2 01111000, duty3 10011111.
REQ-018 Write to addr3 SHALL reset step to 0, set envelope start flag, and, if chan_enable=1, load length from the standard 32-entry APU length table (idx0=10, idx1=254, idx3=2, idx31=30).
REQ-019 chan_enable=0 SHALL force length to 0 every cycle it is low.
REQ-020 On half_tick, length SHALL decrement if halt=0 and length>0; saturate at 0.
REQ-021 Envelope on quarter_tick: if start flag, clear flag, decay=15, divider=vol; else if divider==0, divider=vol and (decay>0 ? decay-1 : loop ? 15 : 0); else divider-1.
REQ-022 Sweep target SHALL be period + (period>>shift), or period - (period>>shift) - (CHANNEL_ID==0 ? 1 : 0) when negate=1, computed 12 bits wide, continuously.
REQ-023 Sweep mute SHALL assert when period<8 or target>2047 (independent of sweep_en).
REQ-024 Sweep on half_tick: if divider==0 and sweep_en and shift!=0 and !mute, period=target[10:0]; then if divider==0 or reload flag, divider=sweep_period and clear reload; else divider-1.
REQ-025 Write to addr1 SHALL set sweep reload flag.
REQ-026 pulse SHALL be 0 when mute, length==0, or duty bit==0; otherwise (const_vol ? vol : decay) << (OUT_WIDTH-4); registered, one clk latency from state change.
REQ-027 Simultaneous write to addr2/addr3 and sweep period update SHALL give the write priority.
REQ-028 Simultaneous addr3 write and half_tick length decrement SHALL give the load priority (no decrement that cycle).
REQ-029 Simultaneous addr3 write and quarter_tick SHALL leave start flag set (envelope restarts next quarter_tick).
REQ-030 Ticks SHALL have no effect while reset=1.

Reset
REQ-031 On reset all registers, timer, step, length, envelope (decay, divider, start), sweep divider and reload flag SHALL clear to 0; pulse=0, length_active=0 the cycle after reset asserts.
REQ-032 Reset asserted mid-note SHALL silence pulse within one clk regardless of tick inputs.

Verification
REQ-033 chan_enable=1, addr0=0xBF, addr2=0x08, addr3=0x08 (len idx1), apu_tick every clk -> pulse toggles 15/0 with duty2 pattern, each step lasting 9 apu_ticks; length_active=1.
REQ-034 addr0=0x05 (envelope, vol 5), addr3 write, quarter_ticks -> decay 15 at first tick, then decrements every 6 quarter_ticks to 0 and holds; with loop=1 wraps to 15.
REQ-035 addr0=0x10 halt=0, addr3=0x18 (idx3 -> 2) -> length_active drops after 2nd half_tick; chan_enable=0 mid-note -> length_active=0 next clk.
REQ-036 period=0x100, addr1=0x89 (en, P=0, negate, shift1), CHANNEL_ID=0 -> period 0x07F after first half_tick; CHANNEL_ID=1 -> 0x080.
REQ-037 period=0x7F0, addr1=0x01 (sweep disabled, shift1) -> target 0xBE8>2047, pulse held 0; period=0x007 -> pulse 0.
REQ-038 Reset pulsed during active note with half_tick and addr3 write same cycle -> all state 0, pulse=0, length_active=0.

Source files
------------

// File: rtl/apu_pulse_channel.sv
// APU pulse (square) channel: 11-bit period timer driving an 8-step duty
// sequencer, length counter, envelope generator and period sweep unit.
// The output level is registered and left-justified in OUT_WIDTH bits.
module apu_pulse_channel #(
    parameter int CHANNEL_ID = 0,
    parameter int OUT_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 apu_tick,
    input  logic                 quarter_tick,
    input  logic                 half_tick,
    input  logic                 wr_en,
    input  logic [1:0]           wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 chan_enable,
    output logic [OUT_WIDTH-1:0] pulse,
    output logic                 length_active
);

    // Channel 0 negates in ones' complement: one extra subtracted.
    localparam logic [11:0] NEG_EXTRA = (CHANNEL_ID == 0) ? 12'd1 : 12'd0;

    // Register file fields
    logic [1:0]  duty_q, duty_d;
    logic        halt_q, halt_d;
    logic        const_vol_q, const_vol_d;
    logic [3:0]  vol_q, vol_d;
    logic        sweep_en_q, sweep_en_d;
    logic [2:0]  sweep_period_q, sweep_period_d;
    logic        negate_q, negate_d;
    logic [2:0]  shift_q, shift_d;
    logic [10:0] period_q, period_d;

    // Sequencer, length, envelope and sweep state
    logic [10:0] timer_q, timer_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  length_q, length_d;
    logic        env_start_q, env_start_d;
    logic [3:0]  env_decay_q, env_decay_d;
    logic [3:0]  env_div_q, env_div_d;
    logic [2:0]  sweep_div_q, sweep_div_d;
    logic        sweep_reload_q, sweep_reload_d;
    logic [OUT_WIDTH-1:0] pulse_q, pulse_d;

    logic        wr0, wr1, wr2, wr3;
    logic [11:0] sweep_change;
    logic [11:0] sweep_target;
    logic        sweep_mute;
    logic [7:0]  duty_pattern;
    logic [3:0]  level;
    logic [OUT_WIDTH-1:0] level_ext;

    // Standard 32-entry APU length counter load table.
    function automatic logic [7:0] length_lookup(input logic [4:0] idx);
        case (idx)
            5'd0:  length_lookup = 8'd10;
            5'd1:  length_lookup = 8'd254;
            5'd2:  length_lookup = 8'd20;
            5'd3:  length_lookup = 8'd2;
            5'd4:  length_lookup = 8'd40;
            5'd5:  length_lookup = 8'd4;
            5'd6:  length_lookup = 8'd80;
            5'd7:  length_lookup = 8'd6;
            5'd8:  length_lookup = 8'd160;
            5'd9:  length_lookup = 8'd8;
            5'd10: length_lookup = 8'd60;
            5'd11: length_lookup = 8'd10;
            5'd12: length_lookup = 8'd14;
            5'd13: length_lookup = 8'd12;
            5'd14: length_lookup = 8'd26;
            5'd15: length_lookup = 8'd14;
            5'd16: length_lookup = 8'd12;
            5'd17: length_lookup = 8'd16;
            5'd18: length_lookup = 8'd24;
            5'd19: length_lookup = 8'd18;
            5'd20: length_lookup = 8'd48;
            5'd21: length_lookup = 8'd20;
            5'd22: length_lookup = 8'd96;
            5'd23: length_lookup = 8'd22;
            5'd24: length_lookup = 8'd192;
            5'd25: length_lookup = 8'd24;
            5'd26: length_lookup = 8'd72;
            5'd27: length_lookup = 8'd26;
            5'd28: length_lookup = 8'd16;
            5'd29: length_lookup = 8'd28;
            5'd30: length_lookup = 8'd32;
            default: length_lookup = 8'd30;
        endcase
    endfunction

    assign wr0 = wr_en && (wr_addr == 2'd0);
    assign wr1 = wr_en && (wr_addr == 2'd1);
    assign wr2 = wr_en && (wr_addr == 2'd2);
    assign wr3 = wr_en && (wr_addr == 2'd3);

    // Sweep target and mute, evaluated continuously from the current period.
    always_comb begin
        sweep_change = {1'b0, period_q} >> shift_q;
        if (negate_q) begin
            sweep_target = {1'b0, period_q} - sweep_change - NEG_EXTRA;
        end else begin
            sweep_target = {1'b0, period_q} + sweep_change;
        end
        sweep_mute = (period_q < 11'd8) || (sweep_target > 12'd2047);
    end

    // Control register fields from $4000/$4001 writes.
    always_comb begin
        duty_d         = duty_q;
        halt_d         = halt_q;
        const_vol_d    = const_vol_q;
        vol_d          = vol_q;
        sweep_en_d     = sweep_en_q;
        sweep_period_d = sweep_period_q;
        negate_d       = negate_q;
        shift_d        = shift_q;
        if (wr0) begin
            duty_d      = wr_data[7:6];
            halt_d      = wr_data[5];
            const_vol_d = wr_data[4];
            vol_d       = wr_data[3:0];
        end
        if (wr1) begin
            sweep_en_d     = wr_data[7];
            sweep_period_d = wr_data[6:4];
            negate_d       = wr_data[3];
            shift_d        = wr_data[2:0];
        end
    end

    // Period timer and downward-counting duty step; an $4003 write restarts the step.
    always_comb begin
        timer_d = timer_q;
        step_d  = step_q;
        if (apu_tick) begin
            if (timer_q == 11'd0) begin
                timer_d = period_q;
                step_d  = step_q - 3'd1;
            end else begin
                timer_d = timer_q - 11'd1;
            end
        end
        if (wr3) begin
            step_d = '0;
        end
    end

    // Length counter: disable clears, a load beats a same-cycle decrement.
    always_comb begin
        length_d = length_q;
        if (half_tick && !halt_q && (length_q != 8'd0)) begin
            length_d = length_q - 8'd1;
        end
        if (wr3 && chan_enable) begin
            length_d = length_lookup(wr_data[7:3]);
        end
        if (!chan_enable) begin
            length_d = '0;
        end
    end

    // Envelope divider/decay; an $4003 write re-arms the start flag after tick handling.
    always_comb begin
        env_start_d = env_start_q;
        env_decay_d = env_decay_q;
        env_div_d   = env_div_q;
        if (quarter_tick) begin
            if (env_start_q) begin
                env_start_d = 1'b0;
                env_decay_d = 4'd15;
                env_div_d   = vol_q;
            end else if (env_div_q == 4'd0) begin
                env_div_d = vol_q;
                if (env_decay_q != 4'd0) begin
                    env_decay_d = env_decay_q - 4'd1;
                end else if (halt_q) begin
                    env_decay_d = 4'd15;
                end else begin
                    env_decay_d = 4'd0;
                end
            end else begin
                env_div_d = env_div_q - 4'd1;
            end
        end
        if (wr3) begin
            env_start_d = 1'b1;
        end
    end

    // Sweep divider and period update; period register writes override the sweep result.
    always_comb begin
        period_d       = period_q;
        sweep_div_d    = sweep_div_q;
        sweep_reload_d = sweep_reload_q;
        if (half_tick) begin
            if ((sweep_div_q == 3'd0) && sweep_en_q && (shift_q != 3'd0) && !sweep_mute) begin
                period_d = sweep_target[10:0];
            end
            if ((sweep_div_q == 3'd0) || sweep_reload_q) begin
                sweep_div_d    = sweep_period_q;
                sweep_reload_d = 1'b0;
            end else begin
                sweep_div_d = sweep_div_q - 3'd1;
            end
        end
        if (wr1) begin
            sweep_reload_d = 1'b1;
        end
        if (wr2) begin
            period_d = {period_q[10:8], wr_data};
        end
        if (wr3) begin
            period_d = {wr_data[2:0], period_q[7:0]};
        end
    end

    // Output level: gated by mute, length and the duty waveform bit.
    always_comb begin
        case (duty_q)
            2'd0:    duty_pattern = 8'b0000_0010;
            2'd1:    duty_pattern = 8'b0000_0110;
            2'd2:    duty_pattern = 8'b0001_1110;
            default: duty_pattern = 8'b1111_1001;
        endcase
        level     = const_vol_q ? vol_q : env_decay_q;
        level_ext = '0;
        level_ext[OUT_WIDTH-1 -: 4] = level;
        if (sweep_mute || (length_q == 8'd0) || !duty_pattern[step_q]) begin
            pulse_d = '0;
        end else begin
            pulse_d = level_ext;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q         <= '0;
            halt_q         <= 1'b0;
            const_vol_q    <= 1'b0;
            vol_q          <= '0;
            sweep_en_q     <= 1'b0;
            sweep_period_q <= '0;
            negate_q       <= 1'b0;
            shift_q        <= '0;
            period_q       <= '0;
            timer_q        <= '0;
            step_q         <= '0;
            length_q       <= '0;
            env_start_q    <= 1'b0;
            env_decay_q    <= '0;
            env_div_q      <= '0;
            sweep_div_q    <= '0;
            sweep_reload_q <= 1'b0;
            pulse_q        <= '0;
        end else begin
            duty_q         <= duty_d;
            halt_q         <= halt_d;
            const_vol_q    <= const_vol_d;
            vol_q          <= vol_d;
            sweep_en_q     <= sweep_en_d;
            sweep_period_q <= sweep_period_d;
            negate_q       <= negate_d;
            shift_q        <= shift_d;
            period_q       <= period_d;
            timer_q        <= timer_d;
            step_q         <= step_d;
            length_q       <= length_d;
            env_start_q    <= env_start_d;
            env_decay_q    <= env_decay_d;
            env_div_q      <= env_div_d;
            sweep_div_q    <= sweep_div_d;
            sweep_reload_q <= sweep_reload_d;
            pulse_q        <= pulse_d;
        end
    end

    assign pulse         = pulse_q;
    assign length_active = (length_q != 8'd0);

endmodule

// File: tb/tb_apu_pulse_channel.sv
// Self-checking bench for apu_pulse_channel: two instances (ones' and
// two's complement sweep, 4- and 6-bit outputs) driven in lockstep.
module tb_apu_pulse_channel;

    logic       clk = 1'b0;
    logic       reset;
    logic       apu_tick;
    logic       quarter_tick;
    logic       half_tick;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       chan_enable;
    logic [3:0] pulse0;
    logic [5:0] pulse1;
    logic       la0, la1;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    string duty_pat[4] = '{"01000000", "01100000", "01111000", "10011111"};

    apu_pulse_channel #(.CHANNEL_ID(0), .OUT_WIDTH(4)) dut0 (
        .clk(clk), .reset(reset), .apu_tick(apu_tick), .quarter_tick(quarter_tick),
        .half_tick(half_tick), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .chan_enable(chan_enable), .pulse(pulse0), .length_active(la0)
    );

    apu_pulse_channel #(.CHANNEL_ID(1), .OUT_WIDTH(6)) dut1 (
        .clk(clk), .reset(reset), .apu_tick(apu_tick), .quarter_tick(quarter_tick),
        .half_tick(half_tick), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .chan_enable(chan_enable), .pulse(pulse1), .length_active(la1)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    function automatic int duty_level(input int d, input int s, input int lvl);
        string p;
        p = duty_pat[d];
        return (p[s] == "1") ? lvl : 0;
    endfunction

    // Advance past one rising edge; outputs are stable 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic idle_inputs();
        apu_tick = 0; quarter_tick = 0; half_tick = 0; wr_en = 0;
        wr_addr = 0; wr_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        chan_enable = 0;
        reset = 1;
        cyc();
        reset = 0;
        chan_enable = 1;
        cyc();
    endtask

    task automatic measure_width(output int w0, output int w1, output int l0, output int l1);
        logic r0, r1, d0, d1;
        r0 = 0; r1 = 0; d0 = 0; d1 = 0;
        w0 = 0; w1 = 0; l0 = 0; l1 = 0;
        apu_tick = 1;
        for (int n = 0; n < 4000 && !(d0 && d1); n++) begin
            cyc();
            if (pulse0 != 0) begin
                if (!d0) begin r0 = 1; w0++; l0 = int'(pulse0); end
            end else if (r0) d0 = 1;
            if (pulse1 != 0) begin
                if (!d1) begin r1 = 1; w1++; l1 = int'(pulse1); end
            end else if (r1) d1 = 1;
        end
        apu_tick = 0;
    endtask

    task automatic test_reset();
        int e;
        idle_inputs();
        chan_enable = 1;
        reset = 1; apu_tick = 1; quarter_tick = 1; half_tick = 1;
        wr_en = 1; wr_addr = 2'd3; wr_data = 8'h08;
        cyc();
        exp_q.push_back(0);
        cyc();
        e = exp_q.pop_front();
        checks++;
        if (pulse0 !== 4'(e)) begin errors++; $display("FAIL reset_pulse0 got %0d exp %0d", pulse0, e); end
        checks++;
        if (pulse1 !== 6'(e)) begin errors++; $display("FAIL reset_pulse1 got %0d exp %0d", pulse1, e); end
        checks++;
        if (la0 !== 1'b0 || la1 !== 1'b0) begin errors++; $display("FAIL reset_length_active got %0b/%0b exp 0", la0, la1); end
        idle_inputs();
        reset = 0;
        cyc();
    endtask

    task automatic test_duty();
        int e, st, k;
        do_reset();
        wr_reg(2'd0, 8'hBF);
        wr_reg(2'd2, 8'h08);
        wr_reg(2'd3, 8'h08);
        apu_tick = 1;
        for (int n = 1; n <= 100; n++) begin
            k = n - 1;
            st = (k == 0) ? 0 : (((7 - (k - 1) / 9) % 8) + 8) % 8;
            exp_q.push_back(duty_level(2, st, 15));
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (pulse0 !== 4'(e)) begin errors++; $display("FAIL duty_pulse0 cyc %0d got %0d exp %0d", n, pulse0, e); end
            checks++;
            if (pulse1 !== 6'(e * 4)) begin errors++; $display("FAIL duty_pulse1 cyc %0d got %0d exp %0d", n, pulse1, e * 4); end
        end
        apu_tick = 0;
        checks++;
        if (la0 !== 1'b1 || la1 !== 1'b1) begin errors++; $display("FAIL duty_length_active got %0b/%0b exp 1", la0, la1); end
    endtask

    task automatic test_envelope(input logic loop_en);
        int e, v;
        do_reset();
        wr_reg(2'd0, loop_en ? 8'hE5 : 8'hC5);
        wr_reg(2'd2, 8'h08);
        wr_reg(2'd3, 8'h08);
        quarter_tick = 1;
        for (int n = 1; n <= 100; n++) begin
            if (n == 1) v = 0;
            else if (loop_en) v = 15 - (((n - 2) / 6) % 16);
            else begin v = 15 - (n - 2) / 6; if (v < 0) v = 0; end
            exp_q.push_back(v);
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (pulse0 !== 4'(e)) begin errors++; $display("FAIL env_pulse0 loop %0b q %0d got %0d exp %0d", loop_en, n, pulse0, e); end
            checks++;
            if (pulse1 !== 6'(e * 4)) begin errors++; $display("FAIL env_pulse1 loop %0b q %0d got %0d exp %0d", loop_en, n, pulse1, e * 4); end
        end
        if (!loop_en) begin
            // $4003 write coincident with a quarter tick: restart lands on the following tick.
            wr_en = 1; wr_addr = 2'd3; wr_data = 8'h08;
            cyc();
            wr_en = 0;
            exp_q.push_back(0);
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (pulse0 !== 4'(e)) begin errors++; $display("FAIL env_restart_hold got %0d exp %0d", pulse0, e); end
            exp_q.push_back(15);
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (pulse0 !== 4'(e)) begin errors++; $display("FAIL env_restart_decay got %0d exp %0d", pulse0, e); end
        end
        quarter_tick = 0;
    endtask

    task automatic test_length();
        int idxs[5] = '{0, 1, 3, 16, 31};
        int lens[5] = '{10, 254, 2, 12, 30};
        int e, cnt;
        do_reset();
        wr_reg(2'd0, 8'h10);
        for (int i = 0; i < 5; i++) begin
            wr_reg(2'd3, 8'(idxs[i] << 3));
            exp_q.push_back(1);
            e = exp_q.pop_front();
            checks++;
            if (la0 !== 1'(e)) begin errors++; $display("FAIL len_load idx %0d got %0b exp %0d", idxs[i], la0, e); end
            half_tick = 1;
            exp_q.push_back(lens[i]);
            cnt = 0;
            while (cnt < 300) begin
                cyc();
                cnt++;
                if (la0 == 1'b0) break;
            end
            e = exp_q.pop_front();
            checks++;
            if (cnt != e) begin errors++; $display("FAIL len_count idx %0d got %0d exp %0d", idxs[i], cnt, e); end
            cyc();
            checks++;
            if (la0 !== 1'b0 || la1 !== 1'b0) begin errors++; $display("FAIL len_saturate idx %0d got %0b/%0b exp 0", idxs[i], la0, la1); end
            half_tick = 0;
        end
        // Load coincident with a half tick: load wins, no decrement that cycle.
        wr_en = 1; wr_addr = 2'd3; wr_data = 8'h18; half_tick = 1;
        cyc();
        wr_en = 0;
        exp_q.push_back(2);
        cnt = 0;
        while (cnt < 10) begin
            cyc();
            cnt++;
            if (la0 == 1'b0) break;
        end
        half_tick = 0;
        e = exp_q.pop_front();
        checks++;
        if (cnt != e) begin errors++; $display("FAIL len_load_priority got %0d exp %0d", cnt, e); end
        // Disabling the channel clears the length on the next clock.
        wr_reg(2'd3, 8'h18);
        chan_enable = 0;
        cyc();
        checks++;
        if (la0 !== 1'b0 || la1 !== 1'b0) begin errors++; $display("FAIL len_disable got %0b/%0b exp 0", la0, la1); end
        wr_reg(2'd3, 8'h08);
        chan_enable = 1;
        cyc();
        checks++;
        if (la0 !== 1'b0) begin errors++; $display("FAIL len_write_disabled got %0b exp 0", la0); end
    endtask

    task automatic test_sweep();
        int w0, w1, l0, l1, e;
        do_reset();
        wr_reg(2'd0, 8'h3F);
        wr_reg(2'd2, 8'h00);
        wr_reg(2'd3, 8'h09);
        wr_reg(2'd1, 8'h89);
        half_tick = 1;
        cyc();
        half_tick = 0;
        exp_q.push_back(16'h7F + 1);
        exp_q.push_back(16'h80 + 1);
        measure_width(w0, w1, l0, l1);
        e = exp_q.pop_front();
        checks++;
        if (w0 != e) begin errors++; $display("FAIL sweep_neg_ch0 width got %0d exp %0d", w0, e); end
        e = exp_q.pop_front();
        checks++;
        if (w1 != e) begin errors++; $display("FAIL sweep_neg_ch1 width got %0d exp %0d", w1, e); end
        checks++;
        if (l0 != 15 || l1 != 60) begin errors++; $display("FAIL sweep_level got %0d/%0d exp 15/60", l0, l1); end
        // Period write coincident with a due sweep update: the write wins.
        wr_en = 1; wr_addr = 2'd2; wr_data = 8'h20; half_tick = 1;
        cyc();
        wr_en = 0; half_tick = 0;
        wr_reg(2'd3, 8'h08);
        exp_q.push_back(16'h20 + 1);
        measure_width(w0, w1, l0, l1);
        e = exp_q.pop_front();
        checks++;
        if (w0 != e || w1 != e) begin errors++; $display("FAIL sweep_write_priority width got %0d/%0d exp %0d", w0, w1, e); end
    endtask

    task automatic test_mute();
        int e;
        logic [7:0] a1 [4]  = '{8'h01, 8'h07, 8'h01, 8'h01};
        logic [7:0] a2 [4]  = '{8'hF0, 8'hF0, 8'h07, 8'h08};
        logic [7:0] a3 [4]  = '{8'h0F, 8'h0F, 8'h08, 8'h08};
        int         ex [4]  = '{0, 15, 0, 15};
        do_reset();
        wr_reg(2'd0, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            wr_reg(2'd2, a2[i]);
            wr_reg(2'd3, a3[i]);
            wr_reg(2'd1, a1[i]);
            exp_q.push_back(ex[i]);
            cyc();
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (pulse0 !== 4'(e)) begin errors++; $display("FAIL mute_pulse0 case %0d got %0d exp %0d", i, pulse0, e); end
            checks++;
            if (pulse1 !== 6'(e * 4)) begin errors++; $display("FAIL mute_pulse1 case %0d got %0d exp %0d", i, pulse1, e * 4); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr_reg(2'd0, 8'hFF);
        wr_reg(2'd2, 8'h08);
        wr_reg(2'd3, 8'h08);
        cyc();
        cyc();
        checks++;
        if (pulse0 !== 4'd15 || pulse1 !== 6'd60 || la0 !== 1'b1) begin
            errors++; $display("FAIL rstmid_active got %0d/%0d/%0b exp 15/60/1", pulse0, pulse1, la0);
        end
        reset = 1; half_tick = 1; quarter_tick = 1; apu_tick = 1;
        wr_en = 1; wr_addr = 2'd3; wr_data = 8'h08;
        for (int n = 0; n < 3; n++) begin
            cyc();
            checks++;
            if (pulse0 !== 4'd0 || pulse1 !== 6'd0 || la0 !== 1'b0 || la1 !== 1'b0) begin
                errors++; $display("FAIL rstmid_hold cyc %0d got %0d/%0d/%0b/%0b exp 0", n, pulse0, pulse1, la0, la1);
            end
        end
        idle_inputs();
        reset = 0;
        cyc();
        cyc();
        checks++;
        if (pulse0 !== 4'd0 || la0 !== 1'b0) begin
            errors++; $display("FAIL rstmid_after got %0d/%0b exp 0/0", pulse0, la0);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        chan_enable = 0;
        test_reset();
        test_duty();
        test_envelope(1'b0);
        test_envelope(1'b1);
        test_length();
        test_sweep();
        test_mute();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
